// File: rtl/writeback_buffer.sv
// In-order writeback buffer between the memory stage and the register-file write port.
// The head issues byte-lane register writes and PC redirects; a retired redirect flushes younger entries.
module writeback_buffer #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  parameter  int DEPTH  = 2,
  localparam int NBYTES = DATA_W / 8,
  localparam int REG_W  = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NBYTES-1:0] in_be,
  input  logic [REG_W-1:0]  in_dest,
  input  logic              in_setpc,
  output logic              rf_we,
  output logic [NBYTES-1:0] rf_be,
  output logic [REG_W-1:0]  rf_dest,
  output logic [DATA_W-1:0] rf_data,
  input  logic              rf_ack,
  output logic              pc_set_o,
  output logic [DATA_W-1:0] pc_value_o,
  output logic [NREG-1:0]   pend_mask,
  output logic [CW-1:0]     count_o
);

  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [NBYTES-1:0] r_be    [DEPTH];
  logic [REG_W-1:0]  r_dest  [DEPTH];
  logic              r_setpc [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_head_vld;
  logic              w_head_wr;
  logic              w_retire;
  logic              w_flush;
  logic              w_push;
  logic [NREG-1:0]   w_pend;
  logic [PW-1:0]     w_off;

  assign w_head_vld = (r_count != '0);
  assign w_head_wr  = w_head_vld && (r_be[r_head] != '0);
  // Stored entries with be=0 always carry setpc, so the non-write branch only needs setpc.
  assign w_retire   = en && w_head_vld && (w_head_wr ? rf_ack : r_setpc[r_head]);
  assign w_flush    = w_retire && r_setpc[r_head];
  assign in_ready   = (r_count < CW'(DEPTH));
  assign w_push     = in_valid && in_ready && !w_flush && ((in_be != '0) || in_setpc);

  assign rf_we      = en && w_head_wr;
  assign rf_be      = rf_we ? r_be[r_head] : '0;
  assign rf_dest    = w_head_vld ? r_dest[r_head] : '0;
  assign rf_data    = w_head_vld ? r_data[r_head] : '0;
  assign pc_set_o   = w_flush;
  assign pc_value_o = w_flush ? r_data[r_head] : '0;
  assign count_o    = r_count;
  assign pend_mask  = w_pend;

  always_comb begin
    w_pend = '0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (({1'b0, w_off} < r_count) && (r_be[i] != '0)) begin
        w_pend[r_dest[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + P_ONE;
      end
      if (w_retire) begin
        r_head <= r_head + P_ONE;
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail]  <= in_data;
      r_be[r_tail]    <= in_be;
      r_dest[r_tail]  <= in_dest;
      r_setpc[r_tail] <= in_setpc;
    end
  end

endmodule
